// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage : MIPS instruction-decode (ID) stage.
//   Holds the 32x32 register file (with same-cycle writeback bypass), decodes
//   immediates and control, resolves BEQ/BNE/J in ID for fetch, detects the
//   load-use hazard, and registers the decoded instruction into ID/EX.
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_valid, i_halt            step enable / freeze of ID/EX and flush_q
//   i_instruction, i_pc_4      instruction and PC+4 from fetch
//   i_wb_write/addr/data       register-file writeback port
//   i_ex_mem_read, i_ex_rt     load currently in EX and its destination
//   i_dbg_addr, o_dbg_data     debug read port (combinational)
//   o_stall, o_pc_src,
//   o_pc_salto                 combinational controls back to fetch
//   o_valid .. o_pc_4          registered ID/EX outputs
// -----------------------------------------------------------------------------
module decode_stage #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int N_REGS  = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic               i_halt,
   input  logic [NB_DATA-1:0] i_instruction,
   input  logic [NB_DATA-1:0] i_pc_4,
   input  logic               i_wb_write,
   input  logic [NB_REG-1:0]  i_wb_addr,
   input  logic [NB_DATA-1:0] i_wb_data,
   input  logic               i_ex_mem_read,
   input  logic [NB_REG-1:0]  i_ex_rt,
   input  logic [NB_REG-1:0]  i_dbg_addr,
   output logic               o_stall,
   output logic               o_pc_src,
   output logic [NB_DATA-1:0] o_pc_salto,
   output logic               o_valid,
   output logic [NB_DATA-1:0] o_rs_data,
   output logic [NB_DATA-1:0] o_rt_data,
   output logic [NB_DATA-1:0] o_imm,
   output logic [NB_REG-1:0]  o_rs,
   output logic [NB_REG-1:0]  o_rt,
   output logic [NB_REG-1:0]  o_rd,
   output logic [NB_REG-1:0]  o_dest,
   output logic [5:0]         o_opcode,
   output logic [5:0]         o_funct,
   output logic               o_reg_write,
   output logic               o_mem_read,
   output logic               o_mem_write,
   output logic [NB_DATA-1:0] o_pc_4,
   output logic [NB_DATA-1:0] o_dbg_data
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] FN_JR    = 6'h08;

   logic [NB_DATA-1:0] r_regs [N_REGS];
   logic               r_flush_q;

   logic [5:0]         w_op, w_fn;
   logic [NB_REG-1:0]  w_rs, w_rt, w_rd;
   logic [15:0]        w_imm16;
   logic               w_wb_en, w_adv, w_sq, w_taken;
   logic               w_is_load, w_is_store, w_is_logic_imm, w_reg_write;
   logic [NB_DATA-1:0] w_rs_val, w_rt_val, w_imm, w_br_tgt, w_j_tgt;
   logic               w_unused;

   assign w_op    = i_instruction[31:26];
   assign w_rs    = i_instruction[25:21];
   assign w_rt    = i_instruction[20:16];
   assign w_rd    = i_instruction[15:11];
   assign w_fn    = i_instruction[5:0];
   assign w_imm16 = i_instruction[15:0];
   // shamt is consumed downstream from the immediate field, not here
   assign w_unused = ^i_instruction[10:6];

   assign w_adv   = i_valid & ~i_halt;
   assign w_wb_en = i_valid & i_wb_write & (i_wb_addr != '0);

   // Reads bypass a write landing on the same edge so ID never sees stale data
   assign w_rs_val   = (w_rs == '0) ? '0 :
                       (w_wb_en && i_wb_addr == w_rs) ? i_wb_data : r_regs[w_rs];
   assign w_rt_val   = (w_rt == '0) ? '0 :
                       (w_wb_en && i_wb_addr == w_rt) ? i_wb_data : r_regs[w_rt];
   assign o_dbg_data = (i_dbg_addr == '0) ? '0 :
                       (w_wb_en && i_wb_addr == i_dbg_addr) ? i_wb_data : r_regs[i_dbg_addr];

   assign w_is_load      = (w_op == 6'h20) | (w_op == 6'h21) | (w_op == 6'h23) |
                           (w_op == 6'h24) | (w_op == 6'h25) | (w_op == 6'h27);
   assign w_is_store     = (w_op == 6'h28) | (w_op == 6'h29) | (w_op == 6'h2B);
   assign w_is_logic_imm = (w_op == 6'h0C) | (w_op == 6'h0D) | (w_op == 6'h0E);
   assign w_reg_write    = ((w_op == OP_RTYPE) & (w_fn != FN_JR)) |
                           (w_op[5:3] == 3'b001) | w_is_load;

   assign w_imm = w_is_logic_imm ? {{(NB_DATA-16){1'b0}}, w_imm16}
                                 : {{(NB_DATA-16){w_imm16[15]}}, w_imm16};

   // Load-use hazard has priority: a stalled branch must not resolve yet
   assign o_stall = i_valid & i_ex_mem_read & (i_ex_rt != '0) &
                    ((i_ex_rt == w_rs) | (i_ex_rt == w_rt));
   assign w_sq    = o_stall | r_flush_q;

   assign w_taken = i_valid & ~w_sq &
                    (((w_op == OP_BEQ) & (w_rs_val == w_rt_val)) |
                     ((w_op == OP_BNE) & (w_rs_val != w_rt_val)) |
                     (w_op == OP_J));

   assign w_br_tgt = i_pc_4 + {{(NB_DATA-18){w_imm16[15]}}, w_imm16, 2'b00};
   assign w_j_tgt  = {i_pc_4[31:28], i_instruction[25:0], 2'b00};

   assign o_pc_src   = w_taken;
   assign o_pc_salto = !w_taken ? '0 : (w_op == OP_J) ? w_j_tgt : w_br_tgt;

   // Register file: writes are not gated by halt so the pipeline can drain
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
      end else if (w_wb_en) begin
         r_regs[i_wb_addr] <= i_wb_data;
      end
   end

   // ID/EX boundary. A squash clears flush_q too: taken is 0 whenever sq is 1.
   always_ff @(posedge i_clk) begin
      if (i_reset || (w_adv && w_sq)) begin
         r_flush_q   <= 1'b0;
         o_valid     <= 1'b0;
         o_rs_data   <= '0;
         o_rt_data   <= '0;
         o_imm       <= '0;
         o_rs        <= '0;
         o_rt        <= '0;
         o_rd        <= '0;
         o_dest      <= '0;
         o_opcode    <= '0;
         o_funct     <= '0;
         o_reg_write <= 1'b0;
         o_mem_read  <= 1'b0;
         o_mem_write <= 1'b0;
         o_pc_4      <= '0;
      end else if (w_adv) begin
         r_flush_q   <= w_taken;
         o_valid     <= 1'b1;
         o_rs_data   <= w_rs_val;
         o_rt_data   <= w_rt_val;
         o_imm       <= w_imm;
         o_rs        <= w_rs;
         o_rt        <= w_rt;
         o_rd        <= w_rd;
         o_dest      <= (w_op == OP_RTYPE) ? w_rd : w_rt;
         o_opcode    <= w_op;
         o_funct     <= w_fn;
         o_reg_write <= w_reg_write;
         o_mem_read  <= w_is_load;
         o_mem_write <= w_is_store;
         o_pc_4      <= i_pc_4;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, valid, halt;
   logic [31:0] instr, pc4;
   logic        wb_write;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_mem_read;
   logic [4:0]  ex_rt, dbg_addr;

   logic        o_stall, o_pc_src, o_valid, o_reg_write, o_mem_read, o_mem_write;
   logic [31:0] o_pc_salto, o_rs_data, o_rt_data, o_imm, o_pc_4, o_dbg_data;
   logic [4:0]  o_rs, o_rt, o_rd, o_dest;
   logic [5:0]  o_opcode, o_funct;

   always #5 clk = ~clk;

   decode_stage dut (
      .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_halt(halt),
      .i_instruction(instr), .i_pc_4(pc4),
      .i_wb_write(wb_write), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
      .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_dbg_addr(dbg_addr),
      .o_stall(o_stall), .o_pc_src(o_pc_src), .o_pc_salto(o_pc_salto),
      .o_valid(o_valid), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
      .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_dest(o_dest),
      .o_opcode(o_opcode), .o_funct(o_funct), .o_reg_write(o_reg_write),
      .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_pc_4(o_pc_4),
      .o_dbg_data(o_dbg_data)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic        vld;
      logic [31:0] rsd, rtd, imm, pc4;
      logic [4:0]  rs, rt, rd, dest;
      logic [5:0]  op, fn;
      logic        rw, mr, mw;
   } idex_t;

   logic [31:0] m_regs [32];
   logic        m_flush;
   idex_t       m_q, e_next;
   logic        e_stall, e_sq, e_taken;
   logic [31:0] e_salto;

   int total = 0;
   int bad   = 0;

   function automatic idex_t zq();
      idex_t z;
      z.vld = 0; z.rsd = 0; z.rtd = 0; z.imm = 0; z.pc4 = 0;
      z.rs = 0; z.rt = 0; z.rd = 0; z.dest = 0; z.op = 0; z.fn = 0;
      z.rw = 0; z.mr = 0; z.mw = 0;
      return z;
   endfunction

   // architectural register value as seen in ID this cycle
   function automatic logic [31:0] m_rd(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (valid && wb_write && wb_addr == a) return wb_data;
      return m_regs[a];
   endfunction

   task automatic eval_model();
      logic [5:0]  op;
      logic [31:0] rsv, rtv;
      logic        br;
      int          off;
      op  = instr[31:26];
      rsv = m_rd(instr[25:21]);
      rtv = m_rd(instr[20:16]);
      e_stall = valid && ex_mem_read && ex_rt != 0 &&
                (ex_rt == instr[25:21] || ex_rt == instr[20:16]);
      e_sq    = e_stall || m_flush;
      br      = (op == 6'h04 && rsv == rtv) || (op == 6'h05 && rsv != rtv) || op == 6'h02;
      e_taken = valid && !e_sq && br;
      off     = $signed(instr[15:0]);
      if (!e_taken)        e_salto = 0;
      else if (op == 6'h02) e_salto = {pc4[31:28], instr[25:0], 2'b00};
      else                 e_salto = pc4 + 32'(off * 4);
      e_next.vld  = 1;
      e_next.rsd  = rsv;
      e_next.rtd  = rtv;
      e_next.rs   = instr[25:21];
      e_next.rt   = instr[20:16];
      e_next.rd   = instr[15:11];
      e_next.op   = op;
      e_next.fn   = instr[5:0];
      e_next.pc4  = pc4;
      e_next.dest = (op == 0) ? instr[15:11] : instr[20:16];
      e_next.imm  = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'd0, instr[15:0]}
                                                      : 32'(off);
      e_next.mr   = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27};
      e_next.mw   = op inside {6'h28, 6'h29, 6'h2B};
      e_next.rw   = (op == 0 && instr[5:0] != 6'h08) || (op >= 6'h08 && op <= 6'h0F) || e_next.mr;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // settle inputs, then compare the combinational outputs
   task automatic settle();
      #1;
      eval_model();
      chk("stall",  o_stall,    e_stall);
      chk("pc_src", o_pc_src,   e_taken);
      chk("salto",  o_pc_salto, e_salto);
      chk("dbg",    o_dbg_data, m_rd(dbg_addr));
   endtask

   // clock edge, advance the model, compare ID/EX
   task automatic step_edge();
      @(posedge clk);
      #1;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 0;
         m_q = zq();
         m_flush = 0;
      end else begin
         if (valid && wb_write && wb_addr != 0) m_regs[wb_addr] = wb_data;
         if (valid && !halt) begin
            m_q     = e_sq ? zq() : e_next;
            m_flush = e_taken;
         end
      end
      chk("valid",   o_valid,     m_q.vld);
      chk("rs_data", o_rs_data,   m_q.rsd);
      chk("rt_data", o_rt_data,   m_q.rtd);
      chk("imm",     o_imm,       m_q.imm);
      chk("rs",      o_rs,        m_q.rs);
      chk("rt",      o_rt,        m_q.rt);
      chk("rd",      o_rd,        m_q.rd);
      chk("dest",    o_dest,      m_q.dest);
      chk("opcode",  o_opcode,    m_q.op);
      chk("funct",   o_funct,     m_q.fn);
      chk("reg_wr",  o_reg_write, m_q.rw);
      chk("mem_rd",  o_mem_read,  m_q.mr);
      chk("mem_wr",  o_mem_write, m_q.mw);
      chk("pc_4",    o_pc_4,      m_q.pc4);
   endtask

   task automatic cyc();
      settle();
      step_edge();
   endtask

   task automatic idle();
      rst = 0; valid = 1; halt = 0; instr = 0; pc4 = 0;
      wb_write = 0; wb_addr = 0; wb_data = 0;
      ex_mem_read = 0; ex_rt = 0; dbg_addr = 0;
   endtask

   logic [5:0] ops [18] = '{6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h04, 6'h08, 6'h09,
                            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h24,
                            6'h28, 6'h2B, 6'h3F};
   logic [5:0] fns [4] = '{6'h20, 6'h08, 6'h25, 6'h00};

   initial begin
      logic [31:0] held;
      idle();
      rst = 1; valid = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      m_q = zq(); m_flush = 0;
      eval_model();
      step_edge();
      step_edge();

      // 1: NOP (sll r0) decodes as a real R-type writing r0
      idle();
      cyc();
      chk("nop_valid", o_valid, 1'b1);
      chk("nop_rw",    o_reg_write, 1'b1);

      // 2: BEQ with equal operands resolves in ID, next instruction squashed
      wb_write = 1; wb_addr = 5; wb_data = 32'h1234; cyc();
      wb_addr = 6; cyc();
      wb_write = 0;
      instr = {6'h04, 5'd5, 5'd6, 16'd3}; pc4 = 32'h100;
      settle();
      chk("beq_src",   o_pc_src,   1'b1);
      chk("beq_salto", o_pc_salto, 32'h10C);
      step_edge();
      instr = {6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20}; pc4 = 32'h10C;
      cyc();
      chk("flush_bubble", o_valid, 1'b0);

      // 3: load-use stall then release
      instr = {6'h00, 5'd7, 5'd2, 5'd1, 5'd0, 6'h20};
      ex_mem_read = 1; ex_rt = 7;
      settle();
      chk("lu_stall", o_stall, 1'b1);
      step_edge();
      chk("lu_bubble", o_valid, 1'b0);
      ex_mem_read = 0;
      cyc();
      chk("lu_rs", o_rs, 5'd7);

      // 4: same-cycle writeback bypass; writes to r0 are ignored
      instr = {6'h00, 5'd3, 5'd0, 5'd4, 5'd0, 6'h25};
      wb_write = 1; wb_addr = 3; wb_data = 32'hDEADBEEF; dbg_addr = 3;
      cyc();
      chk("byp_rs", o_rs_data, 32'hDEADBEEF);
      wb_addr = 0; wb_data = 32'hFFFFFFFF; dbg_addr = 0;
      settle();
      chk("r0_dbg", o_dbg_data, 32'd0);
      step_edge();
      wb_write = 0;

      // 5: immediates and jump target
      instr = {6'h0D, 5'd2, 5'd2, 16'h8000}; cyc();
      chk("ori_imm", o_imm, 32'h00008000);
      instr = {6'h08, 5'd2, 5'd2, 16'h8000}; cyc();
      chk("addi_imm", o_imm, 32'hFFFF8000);
      instr = {6'h02, 26'h0000040}; pc4 = 32'h10000004;
      settle();
      chk("j_salto", o_pc_salto, 32'h10000100);
      step_edge();
      instr = 0; cyc();

      // 6: halt freezes ID/EX while writeback still lands
      instr = {6'h23, 5'd1, 5'd9, 16'h0010}; cyc();
      held = o_imm;
      halt = 1; wb_write = 1; wb_addr = 9; wb_data = 32'hCAFEF00D;
      instr = {6'h0D, 5'd2, 5'd3, 16'h0001};
      for (int i = 0; i < 3; i++) cyc();
      chk("halt_hold", o_imm, held);
      halt = 0; wb_write = 0; dbg_addr = 9;
      cyc();
      chk("halt_wb", o_dbg_data, 32'hCAFEF00D);
      chk("resume_imm", o_imm, 32'h00000001);

      // random traffic, including a mid-run reset
      for (int n = 0; n < 300; n++) begin
         logic [5:0] op;
         op = ops[$urandom_range(0, 17)];
         rst = (n == 150);
         valid = ($urandom_range(0, 9) != 0);
         halt = ($urandom_range(0, 7) == 0);
         wb_write = $urandom_range(0, 1);
         wb_addr = 5'($urandom_range(0, 7));
         wb_data = $urandom;
         ex_mem_read = ($urandom_range(0, 3) == 0);
         ex_rt = 5'($urandom_range(0, 7));
         dbg_addr = 5'($urandom_range(0, 7));
         pc4 = $urandom & 32'hFFFFFFFC;
         if (op == 6'h00)
            instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom), fns[$urandom_range(0, 3)]};
         else if (op == 6'h02)
            instr = {op, 26'($urandom)};
         else
            instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
         if (rst) begin
            settle();
            step_edge();
         end else begin
            cyc();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
